fxp_div: RTL and testbench

Sequential signed fixed-point divider for Q4.12 operands. It computes a / b, the inverse of the array's fixed-point multiply path, and returns a 16-bit Q4.12 quotient. It uses a radix-2 restoring iteration with a valid/ready handshake on both sides. It sits beside the PE multiply datapath for normalisation and scaling steps, and produces one quotient per transaction.

---
 rtl/fxp_div_if.sv | 25 ++
 rtl/fxp_div.sv | 147 ++++++++++++++
 tb/tb_fxp_div.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fxp_div_if.sv
// Operand/result handshake bundle for fxp_div.
// The master drives the operands and out_ready. The slave (divider) drives the rest.
interface fxp_div_if #(
    parameter int INWIDTH = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [INWIDTH-1:0] in_a;
    logic [INWIDTH-1:0] in_b;
    logic               out_valid;
    logic               out_ready;
    logic [INWIDTH-1:0] out_q;
    logic               out_ovf;
    logic               out_dz;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_q, out_ovf, out_dz
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_q, out_ovf, out_dz
    );
endinterface

// File: rtl/fxp_div.sv
// Sequential signed Q4.12 restoring divider with saturation and divide-by-zero flag.
// Define FXP_DIV_ROUND_EN to enable a guard-bit iteration that rounds half away from zero.
module fxp_div #(
    parameter int INWIDTH = 16,
    parameter int FRAC    = 12
) (
    input logic     clk,
    input logic     rst,
    fxp_div_if.slave s
);
    localparam int N = INWIDTH + FRAC;
`ifdef FXP_DIV_ROUND_EN
    localparam int ITERS = N + 1;
`else
    localparam int ITERS = N;
`endif
    localparam int CW = $clog2(ITERS + 1);

    localparam logic [INWIDTH-1:0] MAXQ = {1'b0, {(INWIDTH-1){1'b1}}};
    localparam logic [INWIDTH-1:0] MINQ = {1'b1, {(INWIDTH-1){1'b0}}};
    localparam logic [N:0] QMAXP = {{(N-INWIDTH+2){1'b0}}, {(INWIDTH-1){1'b1}}};
    localparam logic [N:0] QMAXN = QMAXP + 1'b1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    logic [N-1:0]       d;
    logic [INWIDTH-1:0] ub;
    logic [INWIDTH-1:0] rem;
    logic [ITERS-1:0]   q;
    logic [CW-1:0]      cnt;
    logic               sign;
    logic               rdy;
    logic               vld;
    logic [INWIDTH-1:0] qo;
    logic               ovf;
    logic               dz;

    logic [INWIDTH-1:0] ua;
    logic [INWIDTH-1:0] ub_in;
    logic [INWIDTH:0]   rs;
    logic [INWIDTH-1:0] diff;
    logic               qbit;
    logic [INWIDTH-1:0] rem_nxt;
    logic [ITERS-1:0]   q_nxt;
    logic [N:0]         qm;
    logic [INWIDTH-1:0] fin_q;
    logic               fin_ovf;

    assign ua    = s.in_a[INWIDTH-1] ? -s.in_a : s.in_a;
    assign ub_in = s.in_b[INWIDTH-1] ? -s.in_b : s.in_b;

    // Remainder stays below ub, so the modulo difference is exact when kept.
    assign rs      = {rem, d[N-1]};
    assign qbit    = rs >= {1'b0, ub};
    assign diff    = rs[INWIDTH-1:0] - ub;
    assign rem_nxt = qbit ? diff : rs[INWIDTH-1:0];
    assign q_nxt   = {q[ITERS-2:0], qbit};

`ifdef FXP_DIV_ROUND_EN
    assign qm = {1'b0, q_nxt[ITERS-1:1]} + {{N{1'b0}}, q_nxt[0]};
`else
    assign qm = {1'b0, q_nxt};
`endif

    always_comb begin
        fin_q   = qm[INWIDTH-1:0];
        fin_ovf = 1'b0;
        if (!sign && qm > QMAXP) begin
            fin_q   = MAXQ;
            fin_ovf = 1'b1;
        end else if (sign && qm > QMAXN) begin
            fin_q   = MINQ;
            fin_ovf = 1'b1;
        end else if (sign) begin
            fin_q = -qm[INWIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            d     <= '0;
            ub    <= '0;
            rem   <= '0;
            q     <= '0;
            cnt   <= '0;
            sign  <= 1'b0;
            rdy   <= 1'b1;
            vld   <= 1'b0;
            qo    <= '0;
            ovf   <= 1'b0;
            dz    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (s.in_valid && rdy) begin
                        rdy <= 1'b0;
                        if (s.in_b == '0) begin
                            state <= DONE;
                            vld   <= 1'b1;
                            qo    <= s.in_a[INWIDTH-1] ? MINQ : MAXQ;
                            ovf   <= 1'b0;
                            dz    <= 1'b1;
                        end else begin
                            state <= CALC;
                            sign  <= s.in_a[INWIDTH-1] ^ s.in_b[INWIDTH-1];
                            d     <= {ua, {FRAC{1'b0}}};
                            ub    <= ub_in;
                            rem   <= '0;
                            q     <= '0;
                            cnt   <= '0;
                        end
                    end
                end
                CALC: begin
                    d   <= d << 1;
                    rem <= rem_nxt;
                    q   <= q_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(ITERS - 1)) begin
                        state <= DONE;
                        vld   <= 1'b1;
                        qo    <= fin_q;
                        ovf   <= fin_ovf;
                        dz    <= 1'b0;
                    end
                end
                DONE: begin
                    if (s.out_ready) begin
                        state <= IDLE;
                        vld   <= 1'b0;
                        rdy   <= 1'b1;
                        cnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign s.in_ready  = rdy;
    assign s.out_valid = vld;
    assign s.out_q     = qo;
    assign s.out_ovf   = ovf;
    assign s.out_dz    = dz;
endmodule

// File: tb/tb_fxp_div.sv
// Directed self-checking bench for fxp_div.
// Expected quotients are hand-computed Q4.12 values.
module tb_fxp_div;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fxp_div_if #(.INWIDTH(16)) bus ();

    fxp_div #(.INWIDTH(16), .FRAC(12)) dut (
        .clk(clk),
        .rst(rst),
        .s  (bus)
    );

    int checks   = 0;
    int failures = 0;

`ifdef FXP_DIV_ROUND_EN
    localparam int          LAT = 29;
    localparam logic [15:0] Q23 = 16'h0AAB;
`else
    localparam int          LAT = 28;
    localparam logic [15:0] Q23 = 16'h0AAA;
`endif

    task automatic chk(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    task automatic start(input logic [15:0] a,
                         input logic [15:0] b);
        int n = 0;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ready_before_start", 16'(bus.in_ready), 16'h1);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_a     = 16'($urandom);
        bus.in_b     = 16'($urandom);
    endtask

    // Edges counted after the accept edge until out_valid is seen.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic op(input string tag,
                      input logic [15:0] a,
                      input logic [15:0] b,
                      input logic [15:0] eq,
                      input logic eovf,
                      input logic edz,
                      input int elat);
        int lat;
        start(a, b);
        wait_done(lat);
        chk({tag, "_lat"}, 16'(lat), 16'(elat));
        chk({tag, "_q"}, bus.out_q, eq);
        chk({tag, "_ovf"}, 16'(bus.out_ovf), 16'(eovf));
        chk({tag, "_dz"}, 16'(bus.out_dz), 16'(edz));
        @(posedge clk);
        #1;
        chk({tag, "_vld_clr"}, 16'(bus.out_valid), 16'h0);
        chk({tag, "_rdy_set"}, 16'(bus.in_ready), 16'h1);
    endtask

    initial begin
        int  lat;
        logic seen;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        #12;
        chk("rst_ready", 16'(bus.in_ready), 16'h1);
        chk("rst_valid", 16'(bus.out_valid), 16'h0);
        chk("rst_q", bus.out_q, 16'h0000);
        chk("rst_ovf", 16'(bus.out_ovf), 16'h0);
        chk("rst_dz", 16'(bus.out_dz), 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        op("p15_05", 16'h1800, 16'h0800, 16'h3000, 1'b0, 1'b0, LAT);
        op("m1_3", 16'hF000, 16'h3000, 16'hFAAB, 1'b0, 1'b0, LAT);
        op("1_075", 16'h1000, 16'h0C00, 16'h1555, 1'b0, 1'b0, LAT);
        op("2_3", 16'h2000, 16'h3000, Q23, 1'b0, 1'b0, LAT);
        op("q_025", 16'h0800, 16'h2000, 16'h0400, 1'b0, 1'b0, LAT);
        op("zero_a", 16'h0000, 16'hF000, 16'h0000, 1'b0, 1'b0, LAT);
        op("sat_pos", 16'h7000, 16'h0100, 16'h7FFF, 1'b1, 1'b0, LAT);
        op("m8_m1", 16'h8000, 16'hF000, 16'h7FFF, 1'b1, 1'b0, LAT);
        op("m8_1", 16'h8000, 16'h1000, 16'h8000, 1'b0, 1'b0, LAT);
        op("dz_neg", 16'hC000, 16'h0000, 16'h8000, 1'b0, 1'b1, 0);
        op("dz_zero", 16'h0000, 16'h0000, 16'h7FFF, 1'b0, 1'b1, 0);

        bus.out_ready = 1'b0;
        start(16'h1800, 16'h0800);
        wait_done(lat);
        chk("bp_lat", 16'(lat), 16'(LAT));
        chk("bp_q0", bus.out_q, 16'h3000);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.in_a     = 16'($urandom);
            bus.in_b     = 16'h0001;
            @(posedge clk);
            #1;
            chk("bp_q", bus.out_q, 16'h3000);
            chk("bp_flags", {14'h0, bus.out_ovf, bus.out_dz}, 16'h0);
            chk("bp_vld", 16'(bus.out_valid), 16'h1);
            chk("bp_rdy", 16'(bus.in_ready), 16'h0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_rel_vld", 16'(bus.out_valid), 16'h0);
        chk("bp_rel_rdy", 16'(bus.in_ready), 16'h1);
        @(posedge clk);
        #1;
        chk("bp_no_accept", 16'(bus.in_ready), 16'h1);

        start(16'h7000, 16'h1000);
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_rdy", 16'(bus.in_ready), 16'h1);
        chk("arst_vld", 16'(bus.out_valid), 16'h0);
        chk("arst_q", bus.out_q, 16'h0000);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 1'b0;
        repeat (35) begin
            @(posedge clk);
            #1;
            seen = seen | bus.out_valid;
        end
        chk("no_stale", 16'(seen), 16'h0);
        op("post_rst", 16'h2000, 16'h1000, 16'h2000, 1'b0, 1'b0, LAT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
